// File: rtl/mmio_fabric.sv
// Registered request/ready bus fabric between the core data port and up to eight slaves.
// Mask-based address decode, wait states, timeout, bus-error reporting and error capture.
module mmio_fabric #(
  parameter int                  NSLV    = 4,
  parameter logic [NSLV*32-1:0]  BASE    = {32'h3000_0000, 32'h2000_0000, 32'h8000_0000, 32'h1000_0000},
  parameter logic [NSLV*32-1:0]  MASK    = {4{32'hF000_0000}},
  parameter int                  TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 m_req,
  input  logic [31:0]          m_addr,
  input  logic                 m_we,
  input  logic [3:0]           m_be,
  input  logic [31:0]          m_wdata,
  output logic                 m_ack,
  output logic                 m_err,
  output logic [31:0]          m_rdata,
  output logic [NSLV-1:0]      s_sel,
  output logic [31:0]          s_addr,
  output logic                 s_we,
  output logic [3:0]           s_be,
  output logic [31:0]          s_wdata,
  input  logic [NSLV*32-1:0]   s_rdata,
  input  logic [NSLV-1:0]      s_ready,
  input  logic                 err_clr,
  output logic [31:0]          err_addr,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [NSLV-1:0]   r_sel;
  logic [31:0]       r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [7:0]        r_timer;
  logic              r_ack;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       r_err_addr;
  logic [7:0]        r_err_cnt;

  logic [NSLV-1:0]   w_hit;
  logic [NSLV-1:0]   w_hit_first;
  logic [31:0]       w_rd_masked [NSLV];
  logic [31:0]       w_rdata_sel;
  logic              w_ready;
  logic              w_timeout;

  logic [NSLV-1:0]   w_sel_next;
  logic              w_latch;
  logic [7:0]        w_timer_next;
  logic              w_ack_next;
  logic              w_err_next;
  logic [31:0]       w_rdata_next;
  logic              w_err_event;
  logic [31:0]       w_addr_cur;
  logic [7:0]        w_cnt_base;
  logic [7:0]        w_cnt_next;

  // Per-slave window compare and read-data gating by the registered select.
  generate
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
      assign w_hit[gi] = (m_addr & MASK[32*gi +: 32]) == (BASE[32*gi +: 32] & MASK[32*gi +: 32]);
      assign w_rd_masked[gi] = s_rdata[32*gi +: 32] & {32{r_sel[gi]}};
    end
  endgenerate

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
  assign w_hit_first = w_hit & (~w_hit + NSLV'(1));

  always_comb begin
    w_rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_rdata_sel = w_rdata_sel | w_rd_masked[i];
    end
  end

  assign w_ready   = |(s_ready & r_sel);
  assign w_timeout = (r_timer == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_latch      = 1'b0;
    w_timer_next = r_timer;
    w_ack_next   = 1'b0;
    w_err_next   = 1'b0;
    w_rdata_next = r_rdata;
    w_err_event  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_req) begin
          w_latch = 1'b1;
          if (|w_hit) begin
            w_sel_next   = w_hit_first;
            w_timer_next = '0;
            w_state_next = ST_ACCESS;
          end else begin
            w_sel_next   = '0;
            w_ack_next   = 1'b1;
            w_err_next   = 1'b1;
            w_rdata_next = '0;
            w_err_event  = 1'b1;
            w_state_next = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // Ready is tested first so that it wins over a coincident timeout.
        if (w_ready) begin
          w_sel_next   = '0;
          w_rdata_next = w_rdata_sel;
          w_ack_next   = 1'b1;
          w_state_next = ST_RESP;
        end else if (w_timeout) begin
          w_sel_next   = '0;
          w_rdata_next = '0;
          w_ack_next   = 1'b1;
          w_err_next   = 1'b1;
          w_err_event  = 1'b1;
          w_state_next = ST_RESP;
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_sel_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A clear coinciding with an error is applied first, then the error is counted.
  assign w_addr_cur = w_latch ? m_addr : r_addr;
  assign w_cnt_base = err_clr ? 8'd0 : r_err_cnt;
  assign w_cnt_next = !w_err_event ? w_cnt_base :
                      (w_cnt_base == 8'hFF) ? 8'hFF : w_cnt_base + 8'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sel      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_timer    <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_sel   <= w_sel_next;
      r_timer <= w_timer_next;
      r_ack   <= w_ack_next;
      r_err   <= w_err_next;
      r_rdata <= w_rdata_next;
      if (w_latch) begin
        r_addr  <= m_addr;
        r_we    <= m_we;
        r_be    <= m_be;
        r_wdata <= m_wdata;
      end
      if (w_err_event) begin
        r_err_addr <= w_addr_cur;
      end
      r_err_cnt <= w_cnt_next;
    end
  end

  assign m_ack    = r_ack;
  assign m_err    = r_err;
  assign m_rdata  = r_rdata;
  assign s_sel    = r_sel;
  assign s_addr   = r_addr;
  assign s_we     = r_we;
  assign s_be     = r_be;
  assign s_wdata  = r_wdata;
  assign err_addr = r_err_addr;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_mmio_fabric.sv
// Self-checking bench for mmio_fabric: directed cases plus randomized transactions
// compared against a transaction-level reference model of decode, latency and error capture.
module tb_mmio_fabric;

  localparam int NSLV    = 4;
  localparam int TIMEOUT = 16;
  localparam int LIMIT   = 300;

  logic                clk;
  logic                n_rst;
  logic                m_req;
  logic [31:0]         m_addr;
  logic                m_we;
  logic [3:0]          m_be;
  logic [31:0]         m_wdata;
  logic                m_ack;
  logic                m_err;
  logic [31:0]         m_rdata;
  logic [NSLV-1:0]     s_sel;
  logic [31:0]         s_addr;
  logic                s_we;
  logic [3:0]          s_be;
  logic [31:0]         s_wdata;
  logic [NSLV*32-1:0]  s_rdata;
  logic [NSLV-1:0]     s_ready;
  logic                err_clr;
  logic [31:0]         err_addr;
  logic [7:0]          err_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] base_tbl [NSLV];
  int          mdl_cnt;
  logic [31:0] mdl_addr;

  mmio_fabric #(.NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .err_clr(err_clr), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++) begin
      if (a[31:28] == base_tbl[i][31:28]) return i;
    end
    return -1;
  endfunction

  // Starts at a negedge of an IDLE cycle; returns at the negedge of the IDLE cycle after m_ack.
  // wt = number of wait states before the selected slave answers, -1 = never answers.
  task automatic do_txn(input logic [31:0] addr, input bit we, input logic [3:0] be,
                        input logic [31:0] wdata, input int wt, input bit clr,
                        input bit force_d, input logic [31:0] fdata);
    int idx, lat, got;
    logic [3:0] oh, noise;
    bit exp_err;
    logic [31:0] exp_rd;
    logic [NSLV*32-1:0] rv;
    idx    = model_decode(addr);
    oh     = (idx >= 0) ? 4'(1 << idx) : 4'b0000;
    exp_rd = '0;
    if (idx < 0) begin
      lat = 1; exp_err = 1'b1;
    end else if (wt >= 0 && wt <= TIMEOUT - 1) begin
      lat = 2 + wt; exp_err = 1'b0;
    end else begin
      lat = TIMEOUT + 1; exp_err = 1'b1;
    end
    if (clr) mdl_cnt = 0;
    if (exp_err) begin
      mdl_cnt  = (mdl_cnt < 255) ? mdl_cnt + 1 : 255;
      mdl_addr = addr;
    end
    m_req = 1'b1; m_addr = addr; m_we = we; m_be = be; m_wdata = wdata; err_clr = clr;
    got = -1;
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("sel_c1", 32'(s_sel), 32'(oh));
        chk("s_addr", s_addr, addr);
        if (idx >= 0) begin
          chk("s_we_be", 32'({s_we, s_be}), 32'({we, be}));
          chk("s_wdata", s_wdata, wdata);
        end
      end
      if (m_ack) begin
        got = c;
        break;
      end
      if (c > 1) begin
        chk("hold_sel", 32'(s_sel), 32'(oh));
        chk("hold_we_be", 32'({s_we, s_be}), 32'({we, be}));
        chk("hold_wdata", s_wdata, wdata);
      end
      m_req = 1'b0; err_clr = 1'b0;
      rv = {$urandom, $urandom, $urandom, $urandom};
      if (force_d && idx >= 0) rv[32*idx +: 32] = fdata;
      s_rdata = rv;
      noise = 4'($urandom) & ~oh;
      if (idx >= 0 && wt >= 0 && c == 1 + wt) begin
        noise  = noise | oh;
        exp_rd = rv[32*idx +: 32];
      end
      s_ready = noise;
    end
    m_req = 1'b0; err_clr = 1'b0; s_ready = '0;
    chk("latency", 32'(got), 32'(lat));
    if (got > 0) begin
      chk("m_err", 32'(m_err), 32'(exp_err));
      chk("m_rdata", m_rdata, exp_rd);
      chk("sel_at_ack", 32'(s_sel), 32'd0);
      chk("err_cnt", 32'(err_cnt), 32'(mdl_cnt));
      chk("err_addr", err_addr, mdl_addr);
    end
    @(negedge clk);
    chk("ack_strobe", 32'(m_ack), 32'd0);
    $display("[TB] txn addr=%h we=%0d wt=%0d clr=%0d slave=%0d lat=%0d err=%0d rdata=%h cnt=%0d",
             addr, we, wt, clr, idx, got, m_err, m_rdata, err_cnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"}, 32'(m_ack), 32'd0);
    chk({tag, "_err"}, 32'(m_err), 32'd0);
    chk({tag, "_rdata"}, m_rdata, 32'd0);
    chk({tag, "_sel"}, 32'(s_sel), 32'd0);
    chk({tag, "_saddr"}, s_addr, 32'd0);
    chk({tag, "_swe_be"}, 32'({s_we, s_be}), 32'd0);
    chk({tag, "_swdata"}, s_wdata, 32'd0);
    chk({tag, "_erraddr"}, err_addr, 32'd0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    int acks;
    logic [31:0] a;
    logic [3:0] nib;
    logic [3:0] nib_tbl [4];
    int wt, pick;
    base_tbl[0] = 32'h1000_0000; base_tbl[1] = 32'h8000_0000;
    base_tbl[2] = 32'h2000_0000; base_tbl[3] = 32'h3000_0000;
    nib_tbl[0] = 4'h1; nib_tbl[1] = 4'h8; nib_tbl[2] = 4'h2; nib_tbl[3] = 4'h3;
    mdl_cnt = 0; mdl_addr = '0;
    n_rst = 1'b0; m_req = 1'b0; m_addr = '0; m_we = 1'b0; m_be = '0; m_wdata = '0;
    s_rdata = '0; s_ready = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    n_rst = 1'b1;
    @(negedge clk);

    // Directed cases
    do_txn(32'h8000_0010, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'hCAFE_F00D);
    do_txn(32'h1000_0004, 1'b1, 4'b0011, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0);
    do_txn(32'hF000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    do_txn(32'h2000_0100, 1'b0, 4'hF, 32'h0, -1, 1'b0, 1'b0, 32'h0);
    do_txn(32'h3000_0200, 1'b0, 4'hF, 32'h0, TIMEOUT - 1, 1'b0, 1'b1, 32'hA5A5_5A5A);
    do_txn(32'h3000_0300, 1'b0, 4'hF, 32'h0, TIMEOUT, 1'b0, 1'b0, 32'h0);

    // Standalone clear
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mdl_cnt = 0;
    chk("clr_alone", 32'(err_cnt), 32'd0);

    // Saturation then clear together with a miss
    for (int k = 0; k < 256; k++) begin
      do_txn(32'h4000_0000 + 32'(k), 1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    end
    chk("sat_255", 32'(err_cnt), 32'd255);
    do_txn(32'h5000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    chk("clr_with_err", 32'(err_cnt), 32'd1);

    // Reset asserted mid-ACCESS
    m_req = 1'b1; m_addr = 32'h1000_0040; m_we = 1'b0; m_be = 4'hF; s_ready = '0;
    @(negedge clk);
    m_req = 1'b0;
    chk("midrst_sel_before", 32'(s_sel), 32'd1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midrst_sel", 32'(s_sel), 32'd0);
    chk("midrst_ack", 32'(m_ack), 32'd0);
    @(negedge clk);
    chk_reset_state("midrst");
    n_rst = 1'b1;
    mdl_cnt = 0; mdl_addr = '0;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_ack) acks++;
    end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    do_txn(32'h1000_0044, 1'b0, 4'hF, 32'h0, 1, 1'b0, 1'b0, 32'h0);

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      pick = int'($urandom_range(0, 4));
      nib  = (pick < 4) ? nib_tbl[pick] : 4'($urandom);
      a    = {nib, 28'($urandom)};
      case ($urandom_range(0, 7))
        0:       wt = -1;
        1:       wt = TIMEOUT - 1;
        2:       wt = TIMEOUT;
        default: wt = int'($urandom_range(0, 5));
      endcase
      do_txn(a, 1'($urandom), 4'($urandom), $urandom, wt, ($urandom_range(0, 7) == 0),
             1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_fabric.md
# mmio_fabric

Parametrised memory-mapped data-bus fabric between the RV32I core's data port and up to eight slave devices (data memory, test-bench manager, timer, GPIO, UART). It replaces the fixed two-slave address decoder and combinational read-data mux with a registered request/ready transaction engine. Adds mask-based address windows, wait-state support, a timeout, bus-error reporting and an error-capture register.

## Interface

Parameters:
- NSLV, 4: number of slave channels, 1..8.
- BASE, {32'h3000_0000, 32'h2000_0000, 32'h8000_0000, 32'h1000_0000}: packed NSLV*32 base addresses; slave i uses BASE[32*i +: 32].
- MASK, {4{32'hF000_0000}}: packed NSLV*32 compare masks; slave i is hit when (addr & MASK_i) == (BASE_i & MASK_i).
- TIMEOUT, 16: maximum cycles in ACCESS before a bus error; 2..255.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock.
  - n_rst  in  1  reset, asynchronous, active-low.
- Master side:
  - m_req  in  1  request, sampled only in IDLE.
  - m_addr  in  32  byte address.
  - m_we  in  1  1 = write.
  - m_be  in  4  byte enables.
  - m_wdata  in  32  write data.
  - m_ack  out  1  one-cycle completion strobe.
  - m_err  out  1  bus error, qualified by m_ack.
  - m_rdata  out  32  read data, valid with m_ack.
- Slave side:
  - s_sel  out  NSLV  one-hot slave select.
  - s_addr  out  32  latched address.
  - s_we  out  1  latched write flag.
  - s_be  out  4  latched byte enables.
  - s_wdata  out  32  latched write data.
  - s_rdata  in  NSLV*32  per-slave read data.
  - s_ready  in  NSLV  per-slave completion.
- Error capture:
  - err_clr  in  1  clears err_cnt.
  - err_addr  out  32  address of the last errored transaction.
  - err_cnt  out  8  saturating error count.

## Operation

- FSM states are IDLE, ACCESS and RESP.
- IDLE with m_req=1:
  - Latch m_addr, m_we, m_be and m_wdata into s_*.
  - Decode the address; the lowest hit index wins on overlap.
  - Hit: set s_sel to one-hot(i), clear the timer, go to ACCESS.
  - Miss: keep s_sel at 0, set a pending error, go to RESP.
- ACCESS:
  - Hold s_sel and s_*, and increment the timer each cycle.
  - s_ready[i] of the selected slave = 1: capture s_rdata slice i into m_rdata (also captured on writes), clear s_sel, go to RESP with no error.
  - Ready from an unselected slave is ignored.
  - Timer = TIMEOUT-1 with no ready: clear s_sel, set m_rdata = 0, set the pending error, go to RESP.
  - If ready arrives in the same cycle as the timeout, ready wins.
- RESP:
  - m_ack=1 for exactly one cycle; m_err carries the pending error.
  - On a miss or timeout, m_rdata = 0.
  - Return to IDLE. m_req is ignored in RESP.
  - A master still holding m_req in the IDLE cycle after m_ack starts a new transaction.
- Error capture (on entry to RESP with error):
  - err_addr <= latched address.
  - err_cnt increments, saturating at 255.
- err_clr:
  - Alone: err_cnt <= 0 next cycle.
  - Together with an error: err_cnt <= 1, i.e. the clear is applied first and the error then counted.
  - err_addr is not affected by err_clr.

## Timing

- Reset: all outputs are 0 (m_ack, m_err, m_rdata, s_sel, s_*, err_addr, err_cnt); the FSM is in IDLE.
- Reset is asynchronous, so s_sel drops immediately even mid-ACCESS. No m_ack is issued for the aborted transaction.
- Zero-wait slave (ready in the first ACCESS cycle): m_req sampled at edge 0, s_sel high in cycle 1, m_ack in cycle 2. Latency is 2 cycles.
- Each slave wait state adds one cycle.
- Decode miss: m_ack with m_err in cycle 1.
- Timeout: m_ack with m_err exactly TIMEOUT+1 cycles after m_req is sampled.
- Maximum throughput is one transaction per 3 cycles, because IDLE must occur between transactions.
- All outputs are registered; there are no combinational paths from m_* or s_ready to outputs.

## Test plan

- Zero-wait read: slave 1 returns s_rdata = 32'hCAFE_F00D with s_ready=1 on the first ACCESS cycle, m_addr = 32'h8000_0010. Required: s_sel = 4'b0010 in cycle 1; m_ack=1, m_err=0, m_rdata = 32'hCAFE_F00D in cycle 2.
- Write with wait states:
  - Stimulus: write to 32'h1000_0004 with m_be = 4'b0011 and m_wdata = 32'h1234_5678; slave 0 raises ready after 3 waits.
  - Required: s_we=1, s_be = 4'b0011 and s_wdata held stable for 4 cycles; m_ack=1 with m_err=0 in cycle 5.
- Decode miss at 32'hF000_0000. Required: s_sel stays 0; m_ack=1, m_err=1 and m_rdata=0 in cycle 1; err_addr = 32'hF000_0000; err_cnt=1.
- Timeout with TIMEOUT=16 and a slave that never raises ready. Required: m_ack with m_err=1 at cycle 17; s_sel drops at the same time.
- Timeout/ready collision: ready arrives on the timeout cycle. Required: m_err=0 and the data is captured.
- err_cnt saturation and clear: 256 misses, then err_clr together with a miss. Required: err_cnt holds at 255, then becomes 1.
- Reset asserted mid-ACCESS. Required: s_sel=0 immediately; no m_ack; the next m_req is serviced normally.
